// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of data_memory.
// Port 0 is the core load/store unit, port 1 the UART boot loader.
//
// Handshake: a requester raises pN_req with we/byte/addr/wdata and holds them
// stable until the edge where pN_ack is high. A request is accepted on the edge
// that samples it in IDLE; pN_ack is a one-cycle completion pulse, pN_err and
// pN_rdata are meaningful with it. After ACK there is always one IDLE cycle that
// re-samples both requests, so a request kept high is simply served again.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH       = 32,
  parameter bit BYTE_ZERO_EXTEND = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic                  p0_byte,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [31:0]           p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic                  p1_byte,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [31:0]           p1_rdata,
  output logic                  mem_write_word_en,
  output logic                  mem_write_byte_en,
  output logic                  mem_read_word_en,
  output logic                  mem_read_byte_en,
  output logic [ADDR_WIDTH-1:0] mem_write_word_address,
  output logic [ADDR_WIDTH-1:0] mem_write_byte_address,
  output logic [ADDR_WIDTH-1:0] mem_read_word_address,
  output logic [ADDR_WIDTH-1:0] mem_read_byte_address,
  output logic [31:0]           mem_write_word_data,
  output logic [7:0]            mem_write_byte_data,
  input  logic [31:0]           mem_read_word_data,
  input  logic [7:0]            mem_read_byte_data,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched attributes of the transaction in flight. The address and write
  // data are held by the mem_* output registers themselves.
  logic cur_id;
  logic cur_we;
  logic cur_byte;
  logic last_grant;

  logic                  any_req;
  logic                  sel_id;
  logic                  sel_we;
  logic                  sel_byte;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]           sel_wdata;
  logic                  misaligned;
  logic [31:0]           byte_rdata;

  assign dbg_state = state;

  // Round-robin pick: a lone request wins, a tie goes to the port not granted last.
  always_comb begin
    any_req = p0_req | p1_req;
    sel_id  = 1'b0;
    if (p0_req && p1_req) sel_id = ~last_grant;
    else                  sel_id = p1_req;
    sel_we     = sel_id ? p1_we    : p0_we;
    sel_byte   = sel_id ? p1_byte  : p0_byte;
    sel_addr   = sel_id ? p1_addr  : p0_addr;
    sel_wdata  = sel_id ? p1_wdata : p0_wdata;
    misaligned = !sel_byte && (sel_addr[1:0] != 2'b00);
    byte_rdata = BYTE_ZERO_EXTEND ? {24'b0, mem_read_byte_data} : {4{mem_read_byte_data}};
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = misaligned ? ACK : ISSUE;
      ISSUE:   state_next = cur_we ? ACK : RWAIT;
      RWAIT:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any transaction without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Capture the granted request's attributes and remember who won the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id     <= 1'b0;
      cur_we     <= 1'b0;
      cur_byte   <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      cur_id     <= sel_id;
      cur_we     <= sel_we;
      cur_byte   <= sel_byte;
      last_grant <= sel_id;
    end
  end

  // Registered outputs: single-cycle memory enables, ack/err pulses, read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_ack                 <= 1'b0;
      p1_ack                 <= 1'b0;
      p0_err                 <= 1'b0;
      p1_err                 <= 1'b0;
      p0_rdata               <= '0;
      p1_rdata               <= '0;
      mem_write_word_en      <= 1'b0;
      mem_write_byte_en      <= 1'b0;
      mem_read_word_en       <= 1'b0;
      mem_read_byte_en       <= 1'b0;
      mem_write_word_address <= '0;
      mem_write_byte_address <= '0;
      mem_read_word_address  <= '0;
      mem_read_byte_address  <= '0;
      mem_write_word_data    <= '0;
      mem_write_byte_data    <= '0;
    end else begin
      p0_ack            <= 1'b0;
      p1_ack            <= 1'b0;
      p0_err            <= 1'b0;
      p1_err            <= 1'b0;
      mem_write_word_en <= 1'b0;
      mem_write_byte_en <= 1'b0;
      mem_read_word_en  <= 1'b0;
      mem_read_byte_en  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            if (misaligned) begin
              // Rejected word access: straight to ACK with err, memory untouched.
              if (sel_id) begin p1_ack <= 1'b1; p1_err <= 1'b1; end
              else        begin p0_ack <= 1'b1; p0_err <= 1'b1; end
            end else begin
              case ({sel_we, sel_byte})
                2'b10: begin
                  mem_write_word_en      <= 1'b1;
                  mem_write_word_address <= sel_addr;
                  mem_write_word_data    <= sel_wdata;
                end
                2'b11: begin
                  mem_write_byte_en      <= 1'b1;
                  mem_write_byte_address <= sel_addr;
                  mem_write_byte_data    <= sel_wdata[7:0];
                end
                2'b00: begin
                  mem_read_word_en      <= 1'b1;
                  mem_read_word_address <= sel_addr;
                end
                default: begin
                  mem_read_byte_en      <= 1'b1;
                  mem_read_byte_address <= sel_addr;
                end
              endcase
            end
          end
        end
        ISSUE: begin
          if (cur_we) begin
            if (cur_id) p1_ack <= 1'b1;
            else        p0_ack <= 1'b1;
          end
        end
        RWAIT: begin
          // Memory read data is registered, so it is valid during this cycle.
          if (cur_id) begin
            p1_ack   <= 1'b1;
            p1_rdata <= cur_byte ? byte_rdata : mem_read_word_data;
          end else begin
            p0_ack   <= 1'b1;
            p0_rdata <= cur_byte ? byte_rdata : mem_read_word_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small registered-read memory stub.
module tb_data_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_req = 0, p0_we = 0, p0_byte = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0, p1_byte = 0;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en;
  logic [31:0] mem_write_word_address, mem_write_byte_address;
  logic [31:0] mem_read_word_address, mem_read_byte_address;
  logic [31:0] mem_write_word_data;
  logic [7:0]  mem_write_byte_data;
  logic [31:0] mem_read_word_data = 0;
  logic [7:0]  mem_read_byte_data = 0;
  logic [1:0]  dbg_state;

  data_mem_arbiter #(.ADDR_WIDTH(32), .BYTE_ZERO_EXTEND(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte(p0_byte), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte(p1_byte), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_write_word_en(mem_write_word_en), .mem_write_byte_en(mem_write_byte_en),
    .mem_read_word_en(mem_read_word_en), .mem_read_byte_en(mem_read_byte_en),
    .mem_write_word_address(mem_write_word_address), .mem_write_byte_address(mem_write_byte_address),
    .mem_read_word_address(mem_read_word_address), .mem_read_byte_address(mem_read_byte_address),
    .mem_write_word_data(mem_write_word_data), .mem_write_byte_data(mem_write_byte_data),
    .mem_read_word_data(mem_read_word_data), .mem_read_byte_data(mem_read_byte_data),
    .dbg_state(dbg_state)
  );

  // ---------------- memory stub (registered read, little-endian) ----------------
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_write_word_en) begin
      mem[mem_write_word_address[11:0]]         <= mem_write_word_data[7:0];
      mem[mem_write_word_address[11:0] + 12'd1] <= mem_write_word_data[15:8];
      mem[mem_write_word_address[11:0] + 12'd2] <= mem_write_word_data[23:16];
      mem[mem_write_word_address[11:0] + 12'd3] <= mem_write_word_data[31:24];
    end
    if (mem_write_byte_en) mem[mem_write_byte_address[11:0]] <= mem_write_byte_data;
    if (mem_read_word_en)
      mem_read_word_data <= {mem[mem_read_word_address[11:0] + 12'd3], mem[mem_read_word_address[11:0] + 12'd2],
                             mem[mem_read_word_address[11:0] + 12'd1], mem[mem_read_word_address[11:0]]};
    if (mem_read_byte_en) mem_read_byte_data <= mem[mem_read_byte_address[11:0]];
  end

  // ---------------- monitors (sampled mid-cycle) ----------------
  int cnt_wwe = 0, cnt_wbe = 0, cnt_rwe = 0, cnt_rbe = 0;
  int ack0_total = 0, ack1_total = 0, both_ack = 0;
  logic [31:0] last_wwa = 0, last_rwa = 0;
  always @(negedge clk) begin
    if (mem_write_word_en) begin cnt_wwe++; last_wwa = mem_write_word_address; end
    if (mem_write_byte_en) cnt_wbe++;
    if (mem_read_word_en)  begin cnt_rwe++; last_rwa = mem_read_word_address; end
    if (mem_read_byte_en)  cnt_rbe++;
    if (p0_ack) ack0_total++;
    if (p1_ack) ack1_total++;
    if (p0_ack && p1_ack) both_ack++;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int n_checks = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int enables_total();
    return cnt_wwe + cnt_wbe + cnt_rwe + cnt_rbe;
  endfunction

  // ---------------- driver ----------------
  // Called in an IDLE cycle; returns latency in cycles from the accepting edge,
  // and leaves the DUT back in IDLE.
  task automatic do_req(input bit port, input bit we, input bit bsel, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err);
    bit seen = 0;
    if (port) begin p1_we = we; p1_byte = bsel; p1_addr = addr; p1_wdata = wdata; p1_req = 1; end
    else      begin p0_we = we; p0_byte = bsel; p0_addr = addr; p0_wdata = wdata; p0_req = 1; end
    lat = 0;
    rdata = 0;
    err = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (port ? p1_ack : p0_ack) begin
        seen  = 1;
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err : p0_err;
      end
    end
    if (!seen) lat = 99;
    p0_req = 0;
    p1_req = 0;
    @(posedge clk); #1;
  endtask

  int          lat, s0, s1, k;
  logic [31:0] rd, exp0, exp1;
  logic        er;
  logic [31:0] order[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack_err", {28'b0, p0_ack, p1_ack, p0_err, p1_err}, 32'h0);
    check("rst_rdata", p0_rdata | p1_rdata, 32'h0);
    check("rst_en", {28'b0, mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en}, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'h0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // p0 word write
    s0 = cnt_wwe; s1 = enables_total();
    do_req(0, 1, 0, 32'h1000, 32'hDEADBEEF, lat, rd, er);
    check("wr_lat", lat, 2);
    check("wr_err", {31'b0, er}, 0);
    check("wr_en_cycles", cnt_wwe - s0, 1);
    check("wr_en_total", enables_total() - s1, 1);
    check("wr_addr", last_wwa, 32'h1000);

    // p0 word read back
    s0 = cnt_rwe; s1 = enables_total();
    do_req(0, 0, 0, 32'h1000, 32'h0, lat, rd, er);
    check("rd_lat", lat, 3);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_en_cycles", cnt_rwe - s0, 1);
    check("rd_en_total", enables_total() - s1, 1);
    check("rd_addr", last_rwa, 32'h1000);

    // p1 byte writes and byte reads (zero extended)
    do_req(1, 1, 1, 32'h1001, 32'h000000AA, lat, rd, er);
    check("bw0_lat", lat, 2);
    do_req(1, 1, 1, 32'h1003, 32'hFFFFFF55, lat, rd, er);
    check("bw1_lat", lat, 2);
    do_req(1, 0, 1, 32'h1001, 32'h0, lat, rd, er);
    check("br0_lat", lat, 3);
    check("br0_data", rd, 32'h000000AA);
    do_req(1, 0, 1, 32'h1003, 32'h0, lat, rd, er);
    check("br1_data", rd, 32'h00000055);

    // Simultaneous requests: expect strict alternation starting with p0
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    exp0 = 32'hDEADBEEF;
    exp1 = 32'h00000055;
    s0 = both_ack;
    p0_we = 0; p0_byte = 0; p0_addr = 32'h1000;
    p1_we = 0; p1_byte = 1; p1_addr = 32'h1002;
    p0_req = 1; p1_req = 1;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(posedge clk); #1;
      if (p0_ack || p1_ack) begin
        order[k] = p1_ack ? 32'd1 : 32'd0;
        if (p0_ack) exp0 = 32'h55ADAAEF;
        if (p1_ack) exp1 = 32'h000000AD;
        check("rr_p0_rdata", p0_rdata, exp0);
        check("rr_p1_rdata", p1_rdata, exp1);
        k++;
      end
    end
    p0_req = 0; p1_req = 0;
    @(posedge clk); #1;
    check("rr_count", k, 4);
    for (int i = 0; i < 4; i++) if (i < k) check("rr_order", order[i], exp_q[i]);
    check("rr_overlap", both_ack - s0, 0);

    // Misaligned word read
    s1 = enables_total();
    do_req(0, 0, 0, 32'h1002, 32'h0, lat, rd, er);
    check("mis_lat", lat, 1);
    check("mis_err", {31'b0, er}, 1);
    check("mis_rdata", rd, 32'h55ADAAEF);
    check("mis_en_total", enables_total() - s1, 0);

    // Reset during RWAIT
    p0_we = 0; p0_byte = 0; p0_addr = 32'h1000; p0_req = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rw_state", {30'b0, dbg_state}, 32'd2);
    s0 = ack0_total;
    rst_n = 0;
    #1;
    check("ar_ack_err", {28'b0, p0_ack, p1_ack, p0_err, p1_err}, 32'h0);
    check("ar_rdata", p0_rdata | p1_rdata, 32'h0);
    check("ar_en", {28'b0, mem_write_word_en, mem_write_byte_en, mem_read_word_en, mem_read_byte_en}, 32'h0);
    check("ar_addr", mem_read_word_address | mem_write_word_address, 32'h0);
    check("ar_state", {30'b0, dbg_state}, 32'h0);
    p0_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("ar_no_ack", ack0_total - s0, 0);
    do_req(0, 1, 0, 32'h1004, 32'h12345678, lat, rd, er);
    check("post_wr_lat", lat, 2);
    do_req(0, 0, 0, 32'h1004, 32'h0, lat, rd, er);
    check("post_rd_lat", lat, 3);
    check("post_rd_data", rd, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
